// File: rtl/reg_file_sb.sv
// Register file with a write-through bypass, a per-register pending scoreboard for
// RAW hazard detection, and a saturating count of committed writes.
module reg_file_sb #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREG = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rf_we,
    input  logic [4:0]      rf_rd_addr,
    input  logic [XLEN-1:0] rf_rd_data,
    input  logic            wb_done,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic            issue_valid,
    input  logic [4:0]      issue_rd,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic            stall,
    output logic [15:0]     wr_count
);

    logic [XLEN-1:0] regs_q [NREG];
    logic [NREG-1:0] pend_q, pend_d;
    logic [15:0]     wr_count_q, wr_count_d;

    logic wr_commit;
    logic wb_clear;
    logic issue_set;
    logic issue_pend;

    assign wr_commit = rf_we && (rf_rd_addr != '0);
    assign wb_clear  = wb_done && (rf_rd_addr != '0);

    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        if (rs1_addr != '0) begin
            rs1_data = (wr_commit && (rf_rd_addr == rs1_addr)) ? rf_rd_data : regs_q[rs1_addr];
        end
        if (rs2_addr != '0) begin
            rs2_data = (wr_commit && (rf_rd_addr == rs2_addr)) ? rf_rd_data : regs_q[rs2_addr];
        end
    end

    // A completing write-back to the same register resolves the hazard this cycle.
    always_comb begin
        rs1_busy   = pend_q[rs1_addr] && !(wb_done && (rf_rd_addr == rs1_addr));
        rs2_busy   = pend_q[rs2_addr] && !(wb_done && (rf_rd_addr == rs2_addr));
        issue_pend = pend_q[issue_rd] && !(wb_done && (rf_rd_addr == issue_rd));
        stall      = rs1_busy || rs2_busy || (issue_valid && issue_pend);
        issue_set  = issue_valid && (issue_rd != '0) && !stall;
    end

    // Set is applied after clear so that an issue wins over a same-register write-back.
    always_comb begin
        pend_d = pend_q;
        if (wb_clear) begin
            pend_d[rf_rd_addr] = 1'b0;
        end
        if (issue_set) begin
            pend_d[issue_rd] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    always_comb begin
        wr_count_d = wr_count_q;
        if (wr_commit && (wr_count_q != 16'hFFFF)) begin
            wr_count_d = wr_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            pend_q     <= '0;
            wr_count_q <= '0;
        end else begin
            if (wr_commit) begin
                regs_q[rf_rd_addr] <= rf_rd_data;
            end
            pend_q     <= pend_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign wr_count = wr_count_q;

endmodule
